// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} arb_state_t;

   localparam int UART_DW = 8;

   // Index width that stays legal even for a single-bit select.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after ptr
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] winner,
   output logic         any_req
);

   logic [W-1:0] idx;

   // Walk from the farthest slot back to ptr+1 so the nearest request overwrites last.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int k = N; k >= 1; k--) begin
         idx = W'((int'(ptr) + k) % N);
         if (req[idx]) winner = idx;
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-locked round-robin sharing of one UART transmitter
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int  NUM_REQ      = 4,
   parameter int  HOLD_TIMEOUT = 65535,
   localparam int GW           = clog2_safe(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [UART_DW*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [UART_DW-1:0]         tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [GW-1:0]              grant_id,
   output logic                       arb_busy,
   output logic                       lock_err
);

   arb_state_t         state, state_nxt;
   logic [GW-1:0]      ptr;
   logic [GW-1:0]      winner;
   logic               any_req;
   logic [31:0]        idle_cnt;
   logic               last_q;
   logic               own_valid;
   logic               xfer;
   logic               timeout;
   logic [UART_DW-1:0] data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*UART_DW +: UART_DW];
   end

   rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
      .req     (req_valid),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign own_valid = req_valid[grant_id];
   assign arb_busy  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      xfer      = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE:      if (any_req) state_nxt = ISSUE;
         ISSUE: begin
            xfer                = own_valid && !tx_busy;
            req_ready[grant_id] = xfer;
            // A transfer in the same cycle as the deadline always wins.
            if (xfer) begin
               state_nxt = WAIT_ACK;
            end else if (idle_cnt >= 32'(HOLD_TIMEOUT - 1)) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_ACK:  if (tx_busy) state_nxt = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_nxt = last_q ? IDLE : ISSUE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state    <= IDLE;
         ptr      <= GW'(NUM_REQ - 1);
         grant_id <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         lock_err <= 1'b0;
         idle_cnt <= '0;
         last_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         tx_start <= xfer;
         lock_err <= timeout;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id <= winner;
                  idle_cnt <= '0;
               end
            end
            ISSUE: begin
               if (xfer) begin
                  tx_data  <= data_arr[grant_id];
                  last_q   <= req_last[grant_id];
                  idle_cnt <= '0;
               end else if (timeout) begin
                  ptr <= grant_id;
               end else if (!own_valid && idle_cnt != '1) begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q) ptr      <= grant_id;
                  else        idle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - table and scoreboard bench for uart_tx_arb
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int HT = 8;

   logic           clk = 1'b0;
   logic           rst_ = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [8*N-1:0] req_data;
   logic [7:0]     req_bytes [N];
   logic [7:0]     tx_data;
   logic           tx_start;
   logic           tx_busy = 1'b0;
   logic [1:0]     grant_id;
   logic           arb_busy;
   logic           lock_err;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_data[gi*8 +: 8] = req_bytes[gi];
   end

   uart_tx_arb #(.NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .arb_busy  (arb_busy),
      .lock_err  (lock_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r; logic [7:0] b; logic l; logic p;
      int eg; logic [7:0] eb; logic el;
   } vec_t;
   typedef struct { int r; logic [7:0] b; logic l; logic p; } src_t;
   typedef struct { int g; logic [7:0] b; logic last; } exp_t;

   vec_t tbl [18];
   src_t src_q [$];
   exp_t exp_q [$];

   int total = 0, bad = 0;
   int cyc = 0;
   int busy_len = 3, busy_cnt = 0;
   bit foreign_busy = 1'b0, exact_gap = 1'b0;
   int tx_count = 0, start_cyc = 0, lock_cnt = 0, lock_cyc = 0;
   int prev_cyc = -1;
   bit prev_last = 1'b1, prev_start = 1'b0, prev_lock = 1'b0;
   logic [N-1:0] src_en = '1;
   logic [N-1:0] allowed;
   int rel_req = 0, rel_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic drive_srcs();
      logic [N-1:0] seen;
      logic [1:0]   ri;
      seen = '0;
      req_valid = '0;
      req_last = '0;
      foreach (src_q[k]) begin
         ri = 2'(src_q[k].r);
         if (!seen[ri]) begin
            seen[ri] = 1'b1;
            req_valid[ri] = src_en[ri];
            req_last[ri] = src_q[k].l;
            req_bytes[ri] = src_q[k].b;
         end
      end
   endtask

   task automatic pop_src(input logic [1:0] r);
      for (int k = 0; k < src_q.size(); k++) begin
         if (2'(src_q[k].r) == r) begin
            if (src_q[k].p) src_en[r] = 1'b0;
            src_q.delete(k);
            break;
         end
      end
   endtask

   // Transmitter model, requester sources and scoreboard all act mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_) begin
         busy_cnt = 0;
         prev_cyc = -1;
         prev_start = 1'b0;
         prev_lock = 1'b0;
      end else begin
         if (tx_busy || !arb_busy) allowed = '0;
         else                      allowed = N'(1) << grant_id;
         chk("ready_rule", 32'(req_ready & ~allowed), 32'd0);
         chk("start_pulse", 32'(tx_start & prev_start), 32'd0);
         chk("lock_pulse", 32'(lock_err & prev_lock), 32'd0);
         if (tx_start) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("tx_data", 32'(tx_data), 32'(e.b));
               chk("tx_grant", 32'(grant_id), 32'(e.g));
            end else begin
               e = '{-1, 8'h00, 1'b1};
            end
            if (prev_cyc >= 0) begin
               chk("gap_min", 32'((cyc - prev_cyc) >= busy_len + 2), 32'd1);
               if (exact_gap && !prev_last) chk("gap_exact", cyc - prev_cyc, busy_len + 2);
            end
            prev_cyc = cyc;
            prev_last = e.last;
            start_cyc = cyc;
            tx_count++;
            pop_src(grant_id);
         end
         if (lock_err) begin
            lock_cnt++;
            lock_cyc = cyc;
         end
         prev_start = tx_start;
         prev_lock = lock_err;
         if (tx_start)          busy_cnt = busy_len;
         else if (busy_cnt > 0) busy_cnt--;
         if (cyc == rel_cyc) src_en[2'(rel_req)] = 1'b1;
      end
      tx_busy = foreign_busy || (busy_cnt > 0);
      drive_srcs();
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic apply(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         src_q.push_back('{tbl[k].r, tbl[k].b, tbl[k].l, tbl[k].p});
         exp_q.push_back('{tbl[k].eg, tbl[k].eb, tbl[k].el});
      end
   endtask

   task automatic set_busy(input int len);
      busy_len = len;
      prev_cyc = -1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_q.size() != 0 || arb_busy) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic wait_tx(input string name, input int budget);
      int c, n;
      c = tx_count;
      n = 0;
      while (tx_count == c && n < budget) begin
         step();
         n++;
      end
      chk({name, "_seen"}, 32'(tx_count != c), 32'd1);
   endtask

   task automatic wait_grant(input string name, input int g, input int budget);
      int n;
      n = 0;
      while (!(arb_busy && grant_id == 2'(g)) && n < budget) begin
         step();
         n++;
      end
      chk({name, "_grant"}, 32'(grant_id), g);
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
      chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
      chk({name, "_lock_err"}, 32'(lock_err), 32'd0);
      chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({name, "_arb_busy"}, 32'(arb_busy), 32'd0);
   endtask

   initial begin
      int c0, lc0, s0, n;
      //              r  byte    l     p     eg exp     el
      tbl[0]  = '{0, 8'hA0, 1'b1, 1'b0, 0, 8'hA0, 1'b1};
      tbl[1]  = '{1, 8'hA1, 1'b1, 1'b0, 1, 8'hA1, 1'b1};
      tbl[2]  = '{2, 8'hA2, 1'b1, 1'b0, 2, 8'hA2, 1'b1};
      tbl[3]  = '{3, 8'hA3, 1'b1, 1'b0, 3, 8'hA3, 1'b1};
      tbl[4]  = '{1, 8'h66, 1'b1, 1'b0, 1, 8'h66, 1'b1};
      tbl[5]  = '{1, 8'h77, 1'b1, 1'b0, 2, 8'h11, 1'b0};
      tbl[6]  = '{2, 8'h11, 1'b0, 1'b0, 2, 8'h22, 1'b0};
      tbl[7]  = '{2, 8'h22, 1'b0, 1'b0, 2, 8'h33, 1'b1};
      tbl[8]  = '{2, 8'h33, 1'b1, 1'b0, 1, 8'h77, 1'b1};
      tbl[9]  = '{2, 8'hF0, 1'b1, 1'b0, 2, 8'hF0, 1'b1};
      tbl[10] = '{0, 8'h55, 1'b0, 1'b0, 0, 8'h55, 1'b0};
      tbl[11] = '{3, 8'h99, 1'b1, 1'b0, 3, 8'h99, 1'b1};
      tbl[12] = '{0, 8'h5A, 1'b0, 1'b1, 0, 8'h5A, 1'b0};
      tbl[13] = '{0, 8'h5B, 1'b1, 1'b0, 0, 8'h5B, 1'b1};
      tbl[14] = '{1, 8'hC1, 1'b0, 1'b0, 1, 8'hC1, 1'b0};
      tbl[15] = '{1, 8'hC2, 1'b1, 1'b0, 1, 8'hC2, 1'b1};
      tbl[16] = '{2, 8'hD2, 1'b1, 1'b0, 0, 8'hD0, 1'b1};
      tbl[17] = '{0, 8'hD0, 1'b1, 1'b0, 2, 8'hD2, 1'b1};

      // All four single-byte requesters valid through reset.
      apply(0, 3);
      set_busy(3);
      exact_gap = 1'b1;
      step();
      step();
      chk_reset("rst");
      rst_ = 1'b1;
      c0 = tx_count;
      drain("t1", 300);
      chk("t1_starts", tx_count - c0, 32'd4);

      // Locked 3-byte packet from requester 2 with requester 1 pending, slow transmitter.
      set_busy(20);
      apply(4, 8);
      c0 = tx_count;
      drain("t2", 1000);
      chk("t2_starts", tx_count - c0, 32'd5);

      // Stale busy from the line holds ready low until it drops.
      exact_gap = 1'b0;
      set_busy(3);
      foreign_busy = 1'b1;
      apply(9, 9);
      c0 = tx_count;
      repeat (12) step();
      chk("fb_held", tx_count - c0, 32'd0);
      foreign_busy = 1'b0;
      drain("fb", 200);
      chk("fb_starts", tx_count - c0, 32'd1);

      // Owner goes quiet mid-packet: lock revoked, requester 3 next.
      lc0 = lock_cnt;
      apply(10, 10);
      wait_grant("t4", 0, 50);
      apply(11, 11);
      wait_tx("t4", 100);
      s0 = start_cyc;
      drain("t4", 300);
      chk("t4_lock_cnt", lock_cnt - lc0, 32'd1);
      chk("t4_lock_time", lock_cyc - s0, busy_len + 1 + HT);

      // Owner returns on the last idle cycle before the deadline.
      lc0 = lock_cnt;
      apply(12, 13);
      wait_tx("t5", 100);
      rel_req = 0;
      rel_cyc = start_cyc + busy_len + 8;
      drain("t5", 300);
      chk("t5_no_lock", lock_cnt - lc0, 32'd0);
      rel_cyc = -1;

      // Reset while the first byte of a 2-byte packet is on the line.
      set_busy(10);
      apply(14, 15);
      wait_tx("t6", 100);
      repeat (3) step();
      chk("t6_wait_done", 32'(arb_busy && tx_busy), 32'd1);
      rst_ = 1'b0;
      #1;
      chk_reset("t6_rst");
      src_q.delete();
      exp_q.delete();
      step();
      step();
      rst_ = 1'b1;
      set_busy(3);
      apply(16, 17);
      c0 = tx_count;
      n = 0;
      drain("t6", 300);
      chk("t6_starts", tx_count - c0, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
